// File: rtl/appmul_pkg.sv
// rtl/appmul_pkg.sv - shared defaults and mode encoding for the approximate multiplier
package appmul_pkg;
    localparam int         W_DEF       = 8;
    localparam logic [3:0] MASK_DEF    = 4'b1000;
    localparam int         ACC_W_DEF   = 32;
    localparam logic       MODE_EXACT  = 1'b0;
    localparam logic       MODE_APPROX = 1'b1;
endpackage

// File: rtl/appmul_pp.sv
// rtl/appmul_pp.sv - four partial products of the half-split signed multiply
module appmul_pp
    import appmul_pkg::*;
#(
    parameter int             W    = W_DEF,
    parameter logic [W/2-1:0] MASK = (W/2)'(MASK_DEF)
) (
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic            mode,
    output logic signed [W:0] pp_hh,
    output logic signed [W:0] pp_hl,
    output logic signed [W:0] pp_lh,
    output logic signed [W:0] pp_ll
);
    localparam int H = W / 2;

    logic [H-1:0]      al, bl;
    logic signed [W:0] ahx, bhx, alx, blx;

    // High halves are signed, low halves unsigned; one extra bit keeps every product exact.
    always_comb begin
        al    = (mode == MODE_APPROX) ? (a[H-1:0] & MASK) : a[H-1:0];
        bl    = (mode == MODE_APPROX) ? (b[H-1:0] & MASK) : b[H-1:0];
        ahx   = {{(H + 1){a[W-1]}}, a[W-1:H]};
        bhx   = {{(H + 1){b[W-1]}}, b[W-1:H]};
        alx   = {{(H + 1){1'b0}}, al};
        blx   = {{(H + 1){1'b0}}, bl};
        pp_hh = ahx * bhx;
        pp_hl = ahx * blx;
        pp_lh = alx * bhx;
        pp_ll = alx * blx;
    end
endmodule

// File: rtl/appmul_pipe.sv
// rtl/appmul_pipe.sv - three-stage exact/approximate multiplier with error statistics
module appmul_pipe
    import appmul_pkg::*;
#(
    parameter int             W     = W_DEF,
    parameter logic [W/2-1:0] MASK  = (W/2)'(MASK_DEF),
    parameter int             ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   result,
    output logic [2*W-1:0]   actual,
    output logic [2*W-1:0]   diff,
    input  logic             stats_clr,
    output logic [ACC_W-1:0] err_sum,
    output logic [2*W-1:0]   err_max,
    output logic [15:0]      sample_cnt
);
    localparam int H = W / 2;

    logic                  adv, fire;
    logic signed [W:0]     ex_hh, ex_hl, ex_lh, ex_ll;
    logic signed [W:0]     sl_hh, sl_hl, sl_lh, sl_ll;
    logic [3:0][W:0]       s1_ex, s1_sl;
    logic                  s1_v, s2_v;
    logic signed [2*W-1:0] s2_res, s2_act;
    logic [ACC_W:0]        sum_ext;

    function automatic logic signed [2*W-1:0] combine(input logic [3:0][W:0] pp);
        logic signed [2*W-1:0] hh, hl, lh, ll;
        hh = $signed({{(W - 1){pp[3][W]}}, pp[3]});
        hl = $signed({{(W - 1){pp[2][W]}}, pp[2]});
        lh = $signed({{(W - 1){pp[1][W]}}, pp[1]});
        ll = $signed({{(W - 1){pp[0][W]}}, pp[0]});
        return (hh <<< W) + ((hl + lh) <<< H) + ll;
    endfunction

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign fire     = out_valid && out_ready;

    appmul_pp #(.W(W), .MASK(MASK)) u_pp_exact (
        .a(a), .b(b), .mode(MODE_EXACT),
        .pp_hh(ex_hh), .pp_hl(ex_hl), .pp_lh(ex_lh), .pp_ll(ex_ll)
    );

    appmul_pp #(.W(W), .MASK(MASK)) u_pp_sel (
        .a(a), .b(b), .mode(mode),
        .pp_hh(sl_hh), .pp_hl(sl_hl), .pp_lh(sl_lh), .pp_ll(sl_ll)
    );

    // Mode is folded into the selected partial products at S1, so in-flight items keep it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_ex     <= '0;
            s1_sl     <= '0;
            s2_v      <= 1'b0;
            s2_res    <= '0;
            s2_act    <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            actual    <= '0;
            diff      <= '0;
        end else if (adv) begin
            s1_v      <= in_valid;
            s1_ex     <= {ex_hh, ex_hl, ex_lh, ex_ll};
            s1_sl     <= {sl_hh, sl_hl, sl_lh, sl_ll};
            s2_v      <= s1_v;
            s2_act    <= combine(s1_ex);
            s2_res    <= combine(s1_sl);
            out_valid <= s2_v;
            result    <= s2_res;
            actual    <= s2_act;
            diff      <= (s2_res >= s2_act) ? s2_res - s2_act : s2_act - s2_res;
        end
    end

    assign sum_ext = {1'b0, err_sum} + (ACC_W + 1)'(diff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sum    <= '0;
            err_max    <= '0;
            sample_cnt <= '0;
        end else if (stats_clr) begin
            err_sum    <= fire ? ACC_W'(diff) : '0;
            err_max    <= fire ? diff : '0;
            sample_cnt <= fire ? 16'd1 : 16'd0;
        end else if (fire) begin
            if (sample_cnt != '1) begin
                sample_cnt <= sample_cnt + 16'd1;
            end
            err_sum <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            if (diff > err_max) begin
                err_max <= diff;
            end
        end
    end
endmodule

// File: tb/tb_appmul_pipe.sv
// tb/tb_appmul_pipe.sv - randomized self-checking bench for appmul_pipe
module tb_appmul_pipe;
    import appmul_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, mode, out_valid, out_ready, stats_clr;
    logic [7:0]  a, b;
    logic [15:0] result, actual, diff, err_max, sample_cnt;
    logic [31:0] err_sum;

    appmul_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .actual(actual), .diff(diff), .stats_clr(stats_clr),
        .err_sum(err_sum), .err_max(err_max), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint res;
        longint act;
        longint dif;
        bit     lat_ok;
        int     tin;
    } exp_t;

    exp_t        q[$];
    longint      m_sum, m_max, m_cnt;
    int          cyc, passed, total;
    bit          held_v;
    logic [15:0] held_res, held_act, held_dif;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: a = ah*16 + al with floor split; approximate mode masks the low halves.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic md);
        exp_t e;
        int xs, ys, xh, yh, xl, yl, p, r, mk;
        mk = int'(MASK_DEF);
        xs = int'($signed(x));
        ys = int'($signed(y));
        p  = xs * ys;
        xh = xs >>> 4;
        yh = ys >>> 4;
        xl = xs & 15;
        yl = ys & 15;
        if (md) begin
            xl = xl & mk;
            yl = yl & mk;
            r  = xh * yh * 256 + (xh * yl + xl * yh) * 16 + xl * yl;
        end else begin
            r = p;
        end
        e.res    = longint'(r) & 64'hFFFF;
        e.act    = longint'(p) & 64'hFFFF;
        e.dif    = (r > p) ? longint'(r - p) : longint'(p - r);
        e.lat_ok = 1'b1;
        e.tin    = cyc;
        return e;
    endfunction

    task automatic step(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                        input logic md, input logic ordy, input logic clr, output bit acc);
        exp_t e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        mode      = md;
        out_ready = ordy;
        stats_clr = clr;
        #1;
        check("in_ready", in_ready, !(out_valid && !ordy));
        if (held_v) begin
            check("hold_valid", out_valid, 1);
            check("hold_result", result, held_res);
            check("hold_actual", actual, held_act);
            check("hold_diff", diff, held_dif);
        end
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                check("result", result, e.res);
                check("actual", actual, e.act);
                check("diff", diff, e.dif);
                if (e.lat_ok) check("latency", cyc - e.tin, 3);
                if (clr) begin
                    m_cnt = 1; m_sum = e.dif; m_max = e.dif;
                end else begin
                    if (m_cnt < 65535) m_cnt++;
                    m_sum = m_sum + e.dif;
                    if (m_sum > 64'hFFFF_FFFF) m_sum = 64'hFFFF_FFFF;
                    if (e.dif > m_max) m_max = e.dif;
                end
            end
        end else if (clr) begin
            m_cnt = 0; m_sum = 0; m_max = 0;
        end
        if (out_valid && !ordy) begin
            foreach (q[i]) q[i].lat_ok = 1'b0;
        end
        held_v   = out_valid && !ordy;
        held_res = result;
        held_act = actual;
        held_dif = diff;
        acc = iv && in_ready;
        if (acc) q.push_back(model(ia, ib, md));
        @(posedge clk);
        #1;
        cyc++;
        check("sample_cnt", sample_cnt, m_cnt);
        check("err_sum", err_sum, m_sum);
        check("err_max", err_max, m_max);
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 12 && q.size() > 0; k++) step(0, 8'h00, 8'h00, 0, 1, 0, acc);
        check("drained", q.size(), 0);
    endtask

    initial begin
        bit acc;
        int n;
        passed = 0; total = 0; cyc = 0;
        m_sum = 0; m_max = 0; m_cnt = 0; held_v = 0;
        rst = 1'b1; in_valid = 0; a = 0; b = 0; mode = 0; out_ready = 1; stats_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_actual", actual, 0);
        check("rst_diff", diff, 0);
        check("rst_err_sum", err_sum, 0);
        check("rst_err_max", err_max, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        step(0, 8'h00, 8'h00, 0, 1, 1, acc);
        step(1, 8'h37, 8'h25, MODE_APPROX, 1, 0, acc);
        step(1, 8'hFF, 8'hFF, MODE_APPROX, 1, 0, acc);
        drain();
        check("pair_cnt", sample_cnt, 2);
        check("pair_sum", err_sum, 562);
        check("pair_max", err_max, 499);

        step(1, 8'h80, 8'h80, MODE_APPROX, 1, 0, acc);
        step(1, 8'h5A, 8'hC3, MODE_EXACT, 1, 0, acc);
        drain();
        check("zero_diff_sum", err_sum, 562);

        step(1, 8'hFF, 8'hFF, MODE_APPROX, 1, 0, acc);
        step(0, 8'h00, 8'h00, 0, 1, 0, acc);
        step(0, 8'h00, 8'h00, 0, 1, 0, acc);
        step(0, 8'h00, 8'h00, 0, 1, 1, acc);
        check("clr_fire_cnt", sample_cnt, 1);
        check("clr_fire_sum", err_sum, 63);
        check("clr_fire_max", err_max, 63);

        n = 0;
        for (int k = 0; k < 40 && (n < 8 || q.size() > 0); k++) begin
            step(n < 8, 8'($urandom), 8'($urandom), 1'($urandom), !(k >= 4 && k <= 6), 0, acc);
            if (acc) n++;
        end
        check("stream_accepted", n, 8);
        check("stream_drained", q.size(), 0);

        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, acc);
        end
        drain();

        step(1, 8'h12, 8'h34, MODE_APPROX, 1, 0, acc);
        step(1, 8'hA5, 8'h5A, MODE_APPROX, 1, 0, acc);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_cnt", sample_cnt, 0);
        check("midrst_sum", err_sum, 0);
        check("midrst_max", err_max, 0);
        q.delete();
        m_cnt = 0; m_sum = 0; m_max = 0; held_v = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 8'h37, 8'h25, MODE_APPROX, 1, 0, acc);
        drain();
        check("post_rst_cnt", sample_cnt, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/appmul_pipe.md
APPMUL_PIPE -- requirements
Module: appmul_pipe

Interface
REQ-001 Parameter W, default 8, operand width in bits; SHALL be even and >= 4; H = W/2.
REQ-002 Parameter MASK, default 4'b1000 (H bits), keep-mask applied to low operand halves in approximate mode.
REQ-003 Parameter ACC_W, default 32, width of the error accumulator.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  operand pair present.
REQ-007 in_ready  out  1  block accepts operands this cycle.
REQ-008 a, b  in  W each  signed two's-complement operands.
REQ-009 mode  in  1  0 = exact, 1 = approximate; sampled with the operands.
REQ-010 out_valid  out  1  result present.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 result  out  2W  signed product (exact or approximate per sampled mode).
REQ-013 actual  out  2W  signed exact product a*b.
REQ-014 diff  out  2W  unsigned |result - actual|.
REQ-015 stats_clr  in  1  synchronous clear of statistics.
REQ-016 err_sum  out  ACC_W, err_max  out  2W, sample_cnt  out  16  error statistics.

Function
REQ-017 Operand split: a = ah*2^H + al, ah signed H bits, al unsigned H bits; same for b.
REQ-018 Exact: actual = ah*bh*2^(2H) + (ah*bl + al*bh)*2^H + al*bl, full 2W-bit signed, no overflow.
REQ-019 Approximate: al, bl replaced by (al & MASK), (bl & MASK) in REQ-018 formula; high-half product always full precision.
REQ-020 Exact mode: result = actual, diff = 0.
REQ-021 Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
REQ-022 Three-stage pipeline: S1 partial products, S2 summation, S3 diff/output register; latency exactly 3 cycles from input transfer to out_valid with no stall.
REQ-023 Pipeline advance adv = !out_valid || out_ready; all stages hold when adv = 0; in_ready = adv.
REQ-024 Each stage carries its own valid bit; bubbles propagate; throughput one transfer per cycle when out_ready held high.
REQ-025 result, actual, diff SHALL stay stable while out_valid && !out_ready.
REQ-026 On each output transfer: sample_cnt += 1, err_sum += diff, err_max = max(err_max, diff).
REQ-027 err_sum and sample_cnt saturate at all-ones; no wrap-around.
REQ-028 stats_clr zeroes err_sum, err_max, sample_cnt; if coincident with an output transfer, statistics load that sample only (cnt = 1, sum = max = diff).
REQ-029 Mode change between transfers affects only later transactions; in-flight ones keep their sampled mode.

Reset
REQ-030 rst asserted: all stage valids, out_valid, result, actual, diff, err_sum, err_max, sample_cnt = 0; in_ready = 1 after release.
REQ-031 rst mid-operation discards all in-flight transactions; no out_valid until a new input transfer completes 3 cycles later.

Structure
REQ-032 Package appmul_pkg holds defaults for W, MASK, ACC_W and a mode encoding constant (MODE_EXACT = 0, MODE_APPROX = 1).
REQ-033 Combinational sub-module appmul_pp computes the four partial products (ah*bh, ah*bl', al'*bh, al'*bl') from operands, MASK and mode; appmul_pipe instantiates it twice (exact and selected mode) in S1.

Verification (W=8, MASK=4'b1000)
REQ-034 a=0x37, b=0x25, mode=1 -> 3 cycles later result=0x0600, actual=0x07F3, diff=0x01F3.
REQ-035 a=0xFF, b=0xFF, mode=1 -> result=0x0040, actual=0x0001, diff=0x003F; then a=0x80, b=0x80 -> result=actual=0x4000, diff=0.
REQ-036 After REQ-034 then first REQ-035 sample with stats cleared beforehand -> sample_cnt=2, err_sum=562, err_max=499; mode=0 on any pair -> diff=0, statistics sum unchanged.
REQ-037 Stream 8 back-to-back pairs, out_ready low for cycles 4-6 -> no loss, no duplication, outputs held stable, in_ready low while stalled, order preserved.
REQ-038 stats_clr coincident with output transfer of diff=0x003F -> sample_cnt=1, err_sum=63, err_max=63.
REQ-039 rst asserted with 2 transactions in flight -> out_valid and all statistics 0 immediately; next transfer emerges after exactly 3 cycles.
